// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter: round-robin sharing of one single-port BRAM between two requesters with bounded bursts
module bram_rr_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        we0,
  input  logic [3:0]        we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_a,
  output logic [31:0]       bram_di,
  input  logic [31:0]       bram_do
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_n;
  logic last, last_n, rsp_id, own_g1, mine, other, stay;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  assign gnt0    = (state == G0) & req0;
  assign gnt1    = (state == G1) & req1;
  assign bram_en = gnt0 | gnt1;
  assign bram_we = gnt1 ? we1 : gnt0 ? we0 : 4'b0;
  assign bram_a  = 32'(gnt1 ? addr1 : addr0);
  assign bram_di = gnt1 ? wdata1 : wdata0;
  assign rdata0  = (ack0 & ~rsp_id) ? bram_do : '0;
  assign rdata1  = (ack1 & rsp_id) ? bram_do : '0;
  assign own_g1  = state == G1;
  assign mine    = own_g1 ? req1 : req0;
  assign other   = own_g1 ? req0 : req1;
  assign cnt_inc = (int'(cnt) < MAX_BURST) ? cnt + CW'(1) : cnt;
  assign stay    = mine & ((int'(cnt) + 1 < MAX_BURST) | ~other);
  // next grant owner, burst count and tie-break memory
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    last_n  = last;
    if (state == G0 || state == G1) begin
      if (mine) last_n = own_g1;
      state_n = stay ? state : other ? (own_g1 ? G0 : G1) : IDLE;
      cnt_n   = (stay & other) ? cnt_inc : '0;
    end else
      state_n = (req0 & req1) ? (last ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
  end
  // arbitration state and one-cycle response tagging
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rsp_id <= 1'b0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      cnt    <= cnt_n;
      ack0   <= gnt0;
      ack1   <= gnt1;
      rsp_id <= gnt1;
    end
  end
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb_bram_rr_arbiter: vector table, directed corner cases and random run against a reference model
module tb_bram_rr_arbiter;
  localparam int AW = 14;
  localparam int MB = 4;
  typedef struct {
    logic        rst;
    logic        r0;
    logic [3:0]  w0;
    logic [13:0] a0;
    logic [31:0] d0;
    logic        g0;
    logic        k0;
    logic [31:0] rd0;
  } vec_t;
  logic CLK = 0, RST = 0;
  logic req0 = 0, req1 = 0;
  logic [3:0] we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, ack0, ack1, bram_en;
  logic [31:0] rdata0, rdata1, bram_a, bram_di;
  logic [3:0] bram_we;
  logic [31:0] bram_do = 0;
  logic [31:0] mem [int unsigned];
  logic [31:0] shadow [int unsigned];
  int total = 0, bad = 0;
  int holder, streak, prefer, n;
  logic pa0, pa1, gg0, gg1, eg0, eg1;
  logic [31:0] prd, ea, ed, w;
  logic [3:0] ewe;
  vec_t tbl [9];

  always #5 CLK = ~CLK;

  bram_rr_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di), .bram_do(bram_do)
  );

  always @(posedge CLK) begin : bram
    logic [31:0] x;
    if (bram_en) begin
      x = mem.exists(bram_a) ? mem[bram_a] : 32'h0;
      bram_do <= x;
      for (int b = 0; b < 4; b++) if (bram_we[b]) x[b*8 +: 8] = bram_di[b*8 +: 8];
      mem[bram_a] = x;
    end else bram_do <= 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  task automatic do_reset;
    tick;
    RST = 1; req0 = 0; req1 = 0;
    tick;
    tick;
    RST = 0;
  endtask

  task automatic wait_gnt0(input string nm);
    int k;
    k = 0;
    while (!gnt0 && k < 10) begin
      tick;
      smp;
      k++;
    end
    chk(nm, gnt0, 1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'hF, 14'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 4'hF, 14'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 4'hF, 14'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 4'hF, 14'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 4'h0, 14'd5, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 4'h2, 14'd5, 32'h00005500, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b1, 4'h0, 14'd5, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 14'd5, 32'h0, 1'b0, 1'b1, 32'hDEAD55EF};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 14'd5, 32'h0, 1'b0, 1'b0, 32'h0};
    #1 RST = 1;
    for (int i = 0; i < 9; i++) begin
      tick;
      RST = tbl[i].rst; req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      smp;
      chk($sformatf("vec%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("vec%0d_gnt1", i), gnt1, 0);
      chk($sformatf("vec%0d_ack0", i), ack0, tbl[i].k0);
      chk($sformatf("vec%0d_ack1", i), ack1, 0);
      chk($sformatf("vec%0d_rdata0", i), rdata0, tbl[i].rd0);
      chk($sformatf("vec%0d_rdata1", i), rdata1, 0);
      chk($sformatf("vec%0d_en", i), bram_en, tbl[i].g0);
      if (tbl[i].g0) chk($sformatf("vec%0d_addr", i), bram_a, 32'd5);
    end
    // both ports hammer: 4/4 alternation, single bubble out of reset only
    do_reset;
    tick;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 1; addr1 = 2;
    smp;
    chk("t4_bubble", {gnt1, gnt0}, 0);
    for (int k = 0; k < 12; k++) begin
      tick;
      smp;
      chk($sformatf("t4_gnt%0d", k), {gnt1, gnt0}, ((k / 4) % 2) ? 32'd2 : 32'd1);
    end
    // port 1 alone keeps the grant; port 0 then waits exactly MB accepts
    do_reset;
    tick;
    req0 = 0; req1 = 1;
    smp;
    chk("t5_bubble", gnt1, 0);
    for (int k = 0; k < 10; k++) begin
      tick;
      smp;
      chk($sformatf("t5_solo%0d", k), {gnt1, gnt0}, 32'd2);
    end
    tick;
    req0 = 1;
    smp;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (gnt0) break;
      n += int'(gnt1);
      tick;
      smp;
    end
    chk("t5_gnt0_seen", gnt0, 1);
    chk("t5_wait", n, MB);
    // reset kills an in-flight read ack; reissued read returns stored data
    do_reset;
    tick;
    req0 = 1; req1 = 0; we0 = 4'hF; addr0 = 9; wdata0 = 32'h12345678;
    smp;
    wait_gnt0("t6_wr_gnt");
    tick;
    we0 = 0;
    smp;
    chk("t6_rd_gnt", gnt0, 1);
    tick;
    RST = 1; req0 = 0;
    smp;
    chk("t6_ack_killed", ack0, 0);
    chk("t6_rdata_killed", rdata0, 0);
    tick;
    RST = 0; req0 = 1;
    smp;
    chk("t6_idle_bubble", gnt0, 0);
    wait_gnt0("t6_rd2_gnt");
    tick;
    req0 = 0;
    smp;
    chk("t6_ack", ack0, 1);
    chk("t6_rdata", rdata0, 32'h12345678);
    // random traffic against the reference model
    do_reset;
    holder = 2; streak = 0; prefer = 0;
    pa0 = 0; pa1 = 0; gg0 = 0; gg1 = 0; prd = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (gg0 || !req0) begin
        req0 = ($urandom % 4) != 0; we0 = ($urandom % 2) ? 4'($urandom) : 4'd0;
        addr0 = 14'(100 + $urandom % 16); wdata0 = $urandom;
      end else if ($urandom % 16 == 0) req0 = 0;
      if (gg1 || !req1) begin
        req1 = ($urandom % 4) != 0; we1 = ($urandom % 2) ? 4'($urandom) : 4'd0;
        addr1 = 14'(100 + $urandom % 16); wdata1 = $urandom;
      end else if ($urandom % 16 == 0) req1 = 0;
      smp;
      chk("rnd_ack0", ack0, pa0);
      chk("rnd_ack1", ack1, pa1);
      chk("rnd_rdata0", rdata0, pa0 ? prd : 32'h0);
      chk("rnd_rdata1", rdata1, pa1 ? prd : 32'h0);
      eg0 = (holder == 0) && req0;
      eg1 = (holder == 1) && req1;
      chk("rnd_gnt0", gnt0, eg0);
      chk("rnd_gnt1", gnt1, eg1);
      chk("rnd_en", bram_en, eg0 | eg1);
      if (eg0 | eg1) begin
        ea = eg1 ? 32'(addr1) : 32'(addr0);
        ewe = eg1 ? we1 : we0;
        ed = eg1 ? wdata1 : wdata0;
        chk("rnd_addr", bram_a, ea);
        chk("rnd_we", bram_we, ewe);
        chk("rnd_di", bram_di, ed);
        prd = shadow.exists(ea) ? shadow[ea] : 32'h0;
        w = prd;
        for (int b = 0; b < 4; b++) if (ewe[b]) w[b*8 +: 8] = ed[b*8 +: 8];
        shadow[ea] = w;
      end else chk("rnd_we_idle", bram_we, 0);
      pa0 = eg0; pa1 = eg1; gg0 = eg0; gg1 = eg1;
      if (holder == 2) begin
        holder = (req0 && req1) ? prefer : req0 ? 0 : req1 ? 1 : 2;
        streak = 0;
      end else begin
        automatic logic mn = holder == 1 ? req1 : req0;
        automatic logic ot = holder == 1 ? req0 : req1;
        if (mn) prefer = 1 - holder;
        if (mn && ot && streak + 1 < MB) streak++;
        else if (mn && !ot) streak = 0;
        else begin
          holder = ot ? 1 - holder : 2;
          streak = 0;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
